// File: rtl/uart_cfg_regfile.sv
// UART configuration register file: shadow registers written over a valid/ack
// handshake, copied into the active outputs only while the UART is idle.
//
// Handshake: the master raises valid with rd/address/data and holds them until
// it sees ack. ack, err, data_out_valid and data_out are meaningful for the
// single cycle after the accepting edge. The master must then drop valid; a
// new request is accepted no earlier than the edge after valid is sampled low.
module uart_cfg_regfile #(
  parameter int DATA_W          = 4,
  parameter int ADDR_W          = 4,
  parameter int BASE_ADDR       = 9,
  parameter int DEFAULTS_ADDR   = 0,
  parameter int DEF_PARITY      = 1,
  parameter int DEF_PARITY_TYPE = 0,
  parameter int DEF_STOP        = 0,
  parameter int DEF_FRAME       = 8,
  parameter int DEF_BAUD        = 0,
  parameter int FRAME_MIN       = 5,
  parameter int FRAME_MAX       = 9
) (
  input  logic              clk_16bd,
  input  logic              rst,
  input  logic              valid,
  input  logic              rd,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              uart_idle,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              parity,
  output logic              parity_type,
  output logic              stop_bits,
  output logic [DATA_W-1:0] frame_length,
  output logic [DATA_W-1:0] baud_sel,
  output logic              cfg_pending,
  output logic              cfg_update
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESP    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  typedef struct packed {
    logic              parity;
    logic              parity_type;
    logic              stop_bits;
    logic [DATA_W-1:0] frame_length;
    logic [DATA_W-1:0] baud_sel;
  } cfg_t;

  localparam cfg_t CFG_DEF = '{
    parity:       1'(DEF_PARITY),
    parity_type:  1'(DEF_PARITY_TYPE),
    stop_bits:    1'(DEF_STOP),
    frame_length: DATA_W'(DEF_FRAME),
    baud_sel:     DATA_W'(DEF_BAUD)
  };

  localparam logic [ADDR_W-1:0] BASE_A     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] DEFS_A     = ADDR_W'(DEFAULTS_ADDR);
  localparam logic [ADDR_W-1:0] OFF_PARITY = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] OFF_PTYPE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] OFF_STOP   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] OFF_FRAME  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] OFF_BAUD   = ADDR_W'(4);
  localparam logic [DATA_W-1:0] FRAME_LO   = DATA_W'(FRAME_MIN);
  localparam logic [DATA_W-1:0] FRAME_HI   = DATA_W'(FRAME_MAX);

  state_t            state_q, state_d;
  cfg_t              shadow_q, shadow_d;
  cfg_t              active_q, active_d;
  logic              pending_q, pending_d;
  logic              update_q, update_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              dov_q, dov_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  logic [ADDR_W-1:0] offset;
  logic              in_range;
  logic              is_defaults;
  logic              frame_ok;
  logic              commit;
  logic [DATA_W-1:0] rd_val;

  always_comb begin
    offset      = address - BASE_A;
    in_range    = (address >= BASE_A) && (offset <= OFF_BAUD);
    is_defaults = (address == DEFS_A);
    frame_ok    = (data >= FRAME_LO) && (data <= FRAME_HI);
    commit      = pending_q && uart_idle;
  end

  always_comb begin
    rd_val = '0;
    case (offset)
      OFF_PARITY: rd_val = DATA_W'(shadow_q.parity);
      OFF_PTYPE:  rd_val = DATA_W'(shadow_q.parity_type);
      OFF_STOP:   rd_val = DATA_W'(shadow_q.stop_bits);
      OFF_FRAME:  rd_val = shadow_q.frame_length;
      OFF_BAUD:   rd_val = shadow_q.baud_sel;
      default:    rd_val = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    update_d  = 1'b0;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    dov_d     = 1'b0;
    dout_d    = '0;

    // Commit first: a write accepted on the same edge re-arms pending below,
    // so active picks up the pre-write shadow and the new value goes later.
    if (commit) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
      update_d  = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (valid) begin
          state_d = S_RESP;
          ack_d   = 1'b1;
          if (is_defaults) begin
            if (rd) begin
              err_d = 1'b1;
            end else begin
              shadow_d  = CFG_DEF;
              pending_d = 1'b1;
            end
          end else if (in_range) begin
            if (rd) begin
              dov_d  = 1'b1;
              dout_d = rd_val;
            end else if ((offset == OFF_FRAME) && !frame_ok) begin
              err_d = 1'b1;
            end else begin
              pending_d = 1'b1;
              case (offset)
                OFF_PARITY: shadow_d.parity       = data[0];
                OFF_PTYPE:  shadow_d.parity_type  = data[0];
                OFF_STOP:   shadow_d.stop_bits    = data[0];
                OFF_FRAME:  shadow_d.frame_length = data;
                OFF_BAUD:   shadow_d.baud_sel     = data;
                default:    shadow_d              = shadow_q;
              endcase
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RESP:    state_d = S_RELEASE;
      S_RELEASE: if (!valid) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_16bd) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shadow_q  <= CFG_DEF;
      active_q  <= CFG_DEF;
      pending_q <= 1'b0;
      update_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dov_q     <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      update_q  <= update_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      dov_q     <= dov_d;
      dout_q    <= dout_d;
    end
  end

  assign ack            = ack_q;
  assign err            = err_q;
  assign data_out_valid = dov_q;
  assign data_out       = dout_q;
  assign parity         = active_q.parity;
  assign parity_type    = active_q.parity_type;
  assign stop_bits      = active_q.stop_bits;
  assign frame_length   = active_q.frame_length;
  assign baud_sel       = active_q.baud_sel;
  assign cfg_pending    = pending_q;
  assign cfg_update     = update_q;

endmodule

// File: tb/tb_uart_cfg_regfile.sv
// Bench for uart_cfg_regfile: directed scenarios plus random transactions,
// every output compared each cycle against a register-array reference model.
module tb_uart_cfg_regfile;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 4;

  logic              clk_16bd = 1'b0;
  logic              rst;
  logic              valid;
  logic              rd;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              uart_idle;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] data_out;
  logic              data_out_valid;
  logic              parity;
  logic              parity_type;
  logic              stop_bits;
  logic [DATA_W-1:0] frame_length;
  logic [DATA_W-1:0] baud_sel;
  logic              cfg_pending;
  logic              cfg_update;

  always #5 clk_16bd = ~clk_16bd;

  uart_cfg_regfile dut (
    .clk_16bd       (clk_16bd),
    .rst            (rst),
    .valid          (valid),
    .rd             (rd),
    .address        (address),
    .data           (data),
    .uart_idle      (uart_idle),
    .ack            (ack),
    .err            (err),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .parity         (parity),
    .parity_type    (parity_type),
    .stop_bits      (stop_bits),
    .frame_length   (frame_length),
    .baud_sel       (baud_sel),
    .cfg_pending    (cfg_pending),
    .cfg_update     (cfg_update)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  // Reference model: registers indexed 0..4 = parity, parity_type, stop, frame, baud
  int def_v[5] = '{1, 0, 0, 8, 0};
  int m_sh[5];
  int m_act[5];
  bit m_pending;
  bit e_ack, e_err, e_dov, e_upd;
  int e_dout;
  bit accept_now = 1'b0;
  bit chk_en     = 1'b0;

  task automatic model_reset();
    m_sh      = def_v;
    m_act     = def_v;
    m_pending = 1'b0;
    e_ack = 0; e_err = 0; e_dov = 0; e_upd = 0; e_dout = 0;
  endtask

  task automatic model_apply(input bit r, input int a, input int d);
    int idx;
    e_ack = 1'b1;
    if (a == 0) begin
      if (r) e_err = 1'b1;
      else begin
        m_sh      = def_v;
        m_pending = 1'b1;
      end
    end else if (a >= 9 && a <= 13) begin
      idx = a - 9;
      if (r) begin
        e_dov  = 1'b1;
        e_dout = m_sh[idx];
      end else if (idx == 3 && (d < 5 || d > 9)) begin
        e_err = 1'b1;
      end else begin
        m_sh[idx] = (idx < 3) ? (d % 2) : d;
        m_pending = 1'b1;
      end
    end else begin
      e_err = 1'b1;
    end
  endtask

  always @(posedge clk_16bd) begin
    if (rst) model_reset();
    else begin
      e_ack = 0; e_err = 0; e_dov = 0; e_upd = 0; e_dout = 0;
      if (m_pending && uart_idle) begin
        m_act     = m_sh;
        m_pending = 1'b0;
        e_upd     = 1'b1;
      end
      if (accept_now) model_apply(rd, int'(address), int'(data));
    end
  end

  always @(negedge clk_16bd) begin
    if (chk_en) begin
      check_eq("ack", ack, e_ack);
      check_eq("err", err, e_err);
      check_eq("data_out_valid", data_out_valid, e_dov);
      check_eq("data_out", data_out, e_dout);
      check_eq("parity", parity, m_act[0]);
      check_eq("parity_type", parity_type, m_act[1]);
      check_eq("stop_bits", stop_bits, m_act[2]);
      check_eq("frame_length", frame_length, m_act[3]);
      check_eq("baud_sel", baud_sel, m_act[4]);
      check_eq("cfg_pending", cfg_pending, m_pending);
      check_eq("cfg_update", cfg_update, e_upd);
    end
  end

  // Called on a negedge with the DUT free to accept; returns on a negedge
  // with the DUT free again. hold = extra cycles valid stays high after ack.
  task automatic do_txn(input bit r, input int a, input int d, input int hold, input bit rnd_idle);
    valid      = 1'b1;
    rd         = r;
    address    = ADDR_W'(a);
    data       = DATA_W'(d);
    accept_now = 1'b1;
    @(negedge clk_16bd);
    accept_now = 1'b0;
    if (rnd_idle) uart_idle = 1'($urandom);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_16bd);
      if (rnd_idle) uart_idle = 1'($urandom);
    end
    valid   = 1'b0;
    rd      = 1'($urandom);
    address = ADDR_W'($urandom);
    data    = DATA_W'($urandom);
    repeat ((hold == 0) ? 2 : 1) begin
      @(negedge clk_16bd);
      if (rnd_idle) uart_idle = 1'($urandom);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk_16bd);
  endtask

  initial begin
    int a;
    rst       = 1'b1;
    valid     = 1'b0;
    rd        = 1'b0;
    address   = '0;
    data      = '0;
    uart_idle = 1'b0;
    @(negedge clk_16bd);
    chk_en = 1'b1;
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(2);

    // Write parity=0 while busy, then commit once the UART goes idle
    do_txn(1'b0, 9, 0, 0, 1'b0);
    idle_cycles(2);
    uart_idle = 1'b1;
    idle_cycles(3);

    // Read frame_length, bad frame write, unmapped address, read of defaults addr
    do_txn(1'b1, 12, 0, 0, 1'b0);
    do_txn(1'b0, 12, 4, 0, 1'b0);
    do_txn(1'b0, 12, 10, 0, 1'b0);
    do_txn(1'b0, 12, 5, 0, 1'b0);
    do_txn(1'b0, 12, 9, 0, 1'b0);
    do_txn(1'b0, 15, 3, 0, 1'b0);
    do_txn(1'b1, 0, 0, 0, 1'b0);
    do_txn(1'b1, 8, 0, 0, 1'b0);
    do_txn(1'b1, 14, 0, 0, 1'b0);

    // Held valid gives one ack; one-cycle drop then immediate reassert
    do_txn(1'b0, 11, 1, 5, 1'b0);
    do_txn(1'b1, 11, 0, 1, 1'b0);
    idle_cycles(2);

    // Write accepted on the same edge as a pending commit
    uart_idle = 1'b0;
    do_txn(1'b0, 10, 1, 0, 1'b0);
    uart_idle = 1'b1;
    do_txn(1'b0, 13, 3, 0, 1'b0);
    idle_cycles(2);
    do_txn(1'b1, 13, 0, 0, 1'b0);
    do_txn(1'b0, 0, 0, 0, 1'b0);
    idle_cycles(2);

    // Reset coinciding with a request drops it; request then accepted after reset
    uart_idle = 1'b0;
    do_txn(1'b0, 13, 7, 0, 1'b0);
    valid   = 1'b1;
    rd      = 1'b0;
    address = ADDR_W'(9);
    data    = DATA_W'(0);
    rst     = 1'b1;
    @(negedge clk_16bd);
    rst = 1'b0;
    do_txn(1'b0, 9, 0, 0, 1'b0);
    uart_idle = 1'b1;
    idle_cycles(2);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(9, 13));
      do_txn(1'($urandom), a, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b1);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk_16bd);
        uart_idle = 1'($urandom);
      end
    end
    uart_idle = 1'b1;
    idle_cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
